// File: rtl/sar_sample_ctrl_pkg.sv
// Shared definitions for the SAR sample controller: FSM state encoding and
// the conversion-done timeout derived from the SAR resolution.
package sar_sample_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } sar_state_e;

  // Cycles spent in WAIT without sar_done before the conversion is abandoned.
  function automatic int sar_timeout(input int size);
    return 2 * size + 4;
  endfunction

endpackage

// File: rtl/sar_fifo.sv
// Synchronous FIFO for averaged samples. Extra pointer bit separates full
// from empty; the head word is read straight from the storage registers.
module sar_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/sar_sample_ctrl.sv
// SAR ADC sequencer: sample-rate timer, start/wait FSM with done timeout,
// power-of-two averaging and an output FIFO drained over valid/ready.
module sar_sample_ctrl
  import sar_sample_ctrl_pkg::*;
#(
  parameter int SIZE       = 8,
  parameter int DIV_W      = 16,
  parameter int AVG_LOG2   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             sar_start,
  input  logic             sar_done,
  input  logic [SIZE-1:0]  sar_data,
  output logic [SIZE-1:0]  data,
  output logic             valid,
  input  logic             ready,
  output logic             busy,
  output logic             ovf,
  output logic             err,
  input  logic             clr,
  output sar_state_e       dbg_state
);

  localparam int TIMEOUT = sar_timeout(SIZE);
  localparam int TO_W    = $clog2(TIMEOUT);
  localparam int ACC_W   = SIZE + AVG_LOG2;
  localparam int CNT_W   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  sar_state_e       state;
  sar_state_e       state_nxt;
  logic [DIV_W-1:0] tmr;
  logic             tick;
  logic [TO_W-1:0]  wcnt;
  logic             capture;
  logic             timeout;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic [CNT_W-1:0] scnt;
  logic             last;
  logic             push_req;
  logic [SIZE-1:0]  avg;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             ovf_set;
  logic             ovf_q;
  logic             err_q;

  // Sample-period timer; div is sampled only on a reload.
  assign tick = en && (tmr == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmr <= '0;
    end else if (!en || tick) begin
      tmr <= div;
    end else begin
      tmr <= tmr - 1'b1;
    end
  end

  assign capture = (state == ST_WAIT) && sar_done;
  assign timeout = (state == ST_WAIT) && !sar_done && (wcnt == TO_W'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (tick) state_nxt = ST_START;
      ST_START: state_nxt = ST_WAIT;
      ST_WAIT:  if (capture || timeout) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= (state == ST_WAIT) ? wcnt + 1'b1 : '0;
    end
  end

  assign sar_start = (state == ST_START);
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  // Accumulator; a disabled, idle sequencer throws away a partial average.
  assign sum      = acc + ACC_W'(sar_data);
  assign last     = (scnt == CNT_LAST);
  assign push_req = capture && last;
  assign avg      = SIZE'(sum >> AVG_LOG2);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc  <= '0;
      scnt <= '0;
    end else if (capture) begin
      acc  <= last ? '0 : sum;
      scnt <= last ? '0 : scnt + 1'b1;
    end else if (!en && state == ST_IDLE) begin
      acc  <= '0;
      scnt <= '0;
    end
  end

  // Handshake: valid means the FIFO head is on data; a word transfers in any
  // cycle with valid && ready, and data stays put while valid && !ready.
  assign valid   = !fifo_empty;
  assign pop     = valid && ready;
  assign ovf_set = push_req && fifo_full && !pop;

  sar_fifo #(
    .WIDTH (SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push_req),
    .din   (avg),
    .pop   (pop),
    .dout  (data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sticky flags: a set in the same cycle as clr takes priority.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (ovf_set)  ovf_q <= 1'b1;
      else if (clr) ovf_q <= 1'b0;
      if (timeout)  err_q <= 1'b1;
      else if (clr) err_q <= 1'b0;
    end
  end

  assign ovf = ovf_q;
  assign err = err_q;

endmodule

// File: tb/tb_sar_sample_ctrl.sv
// Bench for sar_sample_ctrl: randomized SAR responder, reference averaging
// model feeding an expected queue, and a monitor checking every FIFO pop.
module tb_sar_sample_ctrl;

  localparam int SIZE    = 8;
  localparam int DIV_W   = 16;
  localparam int AVGL    = 2;
  localparam int DEPTH   = 4;
  localparam int NAVG    = 1 << AVGL;
  localparam int TIMEOUT = 2 * SIZE + 4;

  logic             clk = 1'b0;
  logic             rstn;
  logic             en;
  logic [DIV_W-1:0] div;
  logic             sar_start;
  logic             sar_done;
  logic [SIZE-1:0]  sar_data;
  logic [SIZE-1:0]  data;
  logic             valid;
  logic             ready;
  logic             busy;
  logic             ovf;
  logic             err;
  logic             clr;
  sar_sample_ctrl_pkg::sar_state_e dbg_state;

  int checks = 0;
  int errors = 0;

  logic [SIZE-1:0] exp_q[$];
  logic [SIZE-1:0] sar_src_q[$];
  int   occ = 0;
  int   acc_m = 0;
  int   n_m = 0;
  logic exp_ovf = 1'b0;

  int done_cnt = 0;
  bit hang = 1'b0;
  bit sar_inflight = 1'b0;
  int ready_mode = 1;
  int gap_mode = 0;
  bit busy_chk = 1'b0;

  // clock / reset
  always #5 clk = ~clk;

  sar_sample_ctrl #(
    .SIZE       (SIZE),
    .DIV_W      (DIV_W),
    .AVG_LOG2   (AVGL),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .div       (div),
    .sar_start (sar_start),
    .sar_done  (sar_done),
    .sar_data  (sar_data),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .busy      (busy),
    .ovf       (ovf),
    .err       (err),
    .clr       (clr),
    .dbg_state (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // driver tasks
  task automatic wait_dones(input int n, input int budget);
    int target;
    int t;
    target = done_cnt + n;
    t = 0;
    while (done_cnt < target && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("wait_dones", done_cnt >= target, 1);
  endtask

  task automatic flush();
    @(posedge clk);
    #1 en = 1'b0;
    gap_mode = 0;
    busy_chk = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    acc_m = 0;
    n_m = 0;
  endtask

  task automatic clr_pulse();
    @(posedge clk);
    #1 clr = 1'b1;
    exp_ovf = 1'b0;
    @(posedge clk);
    #1 clr = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       ready = 1'b0;
      1:       ready = 1'b1;
      default: ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // SAR core stand-in: done arrives a random number of cycles after start.
  initial begin : sar_model
    int lat;
    bit aborted;
    logic [SIZE-1:0] d;
    sar_done = 1'b0;
    sar_data = '0;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && sar_start === 1'b1 && !hang) begin
        lat = $urandom_range(SIZE + 1, SIZE + 4);
        if (sar_src_q.size() > 0) d = sar_src_q.pop_front();
        else d = SIZE'($urandom_range(0, (1 << SIZE) - 1));
        @(posedge clk);
        sar_inflight = 1'b1;
        aborted = !rstn;
        for (int k = 1; k < lat && !aborted; k++) begin
          @(posedge clk);
          aborted = !rstn;
        end
        if (!aborted) begin
          #1;
          if (rstn) begin
            sar_done = 1'b1;
            sar_data = d;
            done_cnt++;
            @(posedge clk);
            #1;
          end
          sar_done = 1'b0;
        end
        sar_inflight = 1'b0;
      end
    end
  end

  // Reference model: every NAVG captured samples give one truncated mean,
  // queued unless the output store already holds DEPTH words.
  always @(negedge clk) begin : ref_model
    bit pop_m;
    if (rstn === 1'b1) begin
      pop_m = (ready === 1'b1) && (occ > 0);
      if (sar_done) begin
        acc_m += int'(sar_data);
        n_m++;
        if (n_m == NAVG) begin
          if (occ - int'(pop_m) < DEPTH) begin
            exp_q.push_back(SIZE'(acc_m / NAVG));
            occ++;
          end else begin
            exp_ovf = 1'b1;
          end
          acc_m = 0;
          n_m = 0;
        end
      end
      if (pop_m) occ--;
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin : monitor
    if (rstn === 1'b1 && valid === 1'b1 && ready === 1'b1) begin
      if (exp_q.size() == 0) check("pop_unexpected", valid, 0);
      else check("pop_data", data, exp_q.pop_front());
    end
  end

  int cyc = 0;
  int last_start = 0;
  bit have_last = 1'b0;
  logic prev_start = 1'b0;
  int idle_run = 0;
  bit seen_busy = 1'b0;

  always @(negedge clk) begin : start_chk
    cyc++;
    if (rstn === 1'b1) begin
      if (sar_start === 1'b1) begin
        check("start_pulse", prev_start, 0);
        check("start_overlap", sar_inflight, 0);
        if (gap_mode == 1 && have_last) check("start_gap", cyc - last_start, int'(div) + 1);
        last_start = cyc;
        have_last = 1'b1;
      end
      if (busy_chk) begin
        if (!busy) idle_run++;
        else begin
          if (seen_busy && idle_run > 0) check_rng("idle_gap", idle_run, 1, int'(div) + 1);
          idle_run = 0;
          seen_busy = 1'b1;
        end
      end else begin
        idle_run = 0;
        seen_busy = 1'b0;
      end
    end
    if (gap_mode == 0) have_last = 1'b0;
    prev_start = sar_start;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int t;
    int n;
    rstn = 1'b0; en = 1'b0; div = 16'd19; ready = 1'b0; clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_start", sar_start, 0);
    check("rst_valid", valid, 0);
    check("rst_data", data, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    check("rst_err", err, 0);
    @(posedge clk);
    #1 rstn = 1'b1;

    // random data at a fixed rate, random consumer stalls
    ready_mode = 2; div = 16'd19; gap_mode = 1;
    @(posedge clk);
    #1 en = 1'b1;
    wait_dones(12, 12 * 25 + 40);
    flush();
    ready_mode = 1;
    repeat (10) @(negedge clk);
    check("t1_drained", exp_q.size(), 0);
    check("t1_valid", valid, 0);

    // partial average discarded, then a known 4-sample group
    @(posedge clk);
    #1 en = 1'b1;
    wait_dones(2, 80);
    flush();
    sar_src_q = '{8'h10, 8'h11, 8'h12, 8'h14};
    @(posedge clk);
    #1 en = 1'b1;
    wait_dones(3, 3 * 25 + 40);
    repeat (2) @(negedge clk);
    check("t2_no_early_push", valid, 0);
    wait_dones(1, 60);
    @(negedge clk);
    check("t2_valid", valid, 1);
    check("t2_data", data, 8'h11);
    flush();

    // overflow with a stalled consumer, in-order drain, clear
    ready_mode = 0; div = 16'd12;
    @(posedge clk);
    #1 en = 1'b1;
    wait_dones(5 * NAVG, 5 * NAVG * 30);
    flush();
    check("t3_ovf", ovf, exp_ovf);
    check("t3_valid_full", valid, occ > 0);
    ready_mode = 1;
    repeat (10) @(negedge clk);
    check("t3_drained", exp_q.size(), 0);
    check("t3_valid_empty", valid, 0);
    check("t3_ovf_hold", ovf, exp_ovf);
    clr_pulse();
    @(negedge clk);
    check("t3_ovf_clr", ovf, exp_ovf);

    // SAR never answers: timeout, error flag, restart on a later tick
    hang = 1'b1; div = 16'd29;
    @(posedge clk);
    #1 en = 1'b1;
    t = 0;
    while (sar_start !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("t4_first_start", sar_start, 1);
    n = 0;
    while (err !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("t4_err_latency", n, TIMEOUT + 1);
    check("t4_idle", busy, 0);
    while (sar_start !== 1'b1 && n < 80) begin
      @(negedge clk);
      n++;
    end
    check("t4_restart", n, 30);
    flush();
    hang = 1'b0;
    check("t4_err_sticky", err, 1);
    check("t4_no_push", valid, 0);
    clr_pulse();
    @(negedge clk);
    check("t4_err_clr", err, 0);

    // period shorter than a conversion: back-to-back, never overlapping
    ready_mode = 2; div = 16'd3; busy_chk = 1'b1;
    @(posedge clk);
    #1 en = 1'b1;
    wait_dones(16, 16 * 25);
    flush();
    ready_mode = 1;
    repeat (10) @(negedge clk);
    check("t5_drained", exp_q.size(), 0);

    // reset during WAIT with two words queued
    ready_mode = 0; div = 16'd12;
    @(posedge clk);
    #1 en = 1'b1;
    wait_dones(2 * NAVG, 2 * NAVG * 30);
    t = 0;
    while (sar_start !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("t6_start_seen", sar_start, 1);
    repeat (3) @(negedge clk);
    check("t6_pre_valid", valid, occ > 0);
    check("t6_pre_busy", busy, 1);
    #2 rstn = 1'b0;
    exp_q.delete();
    occ = 0; acc_m = 0; n_m = 0; exp_ovf = 1'b0;
    #1;
    check("t6_rst_valid", valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_start", sar_start, 0);
    check("t6_rst_data", data, 0);
    repeat (3) @(negedge clk);
    #2 rstn = 1'b1;
    ready_mode = 1;
    wait_dones(2 * NAVG, 2 * NAVG * 30);
    flush();
    repeat (10) @(negedge clk);
    check("t6_resume_drained", exp_q.size(), 0);
    check("t6_resume_valid", valid, 0);
    check("t6_ovf", ovf, exp_ovf);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
